seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display, directly upstream of the hex7seg decoder.
- Takes a 16-bit hex/BCD value and per-digit decimal points, and emits one nibble at a time on x for the decoder.
- Drives the active-low digit anodes and the active-low decimal point.
- Captures the display value once per frame so a running stopwatch count never tears mid-scan.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; legal range is 2 or more.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (anti-ghosting); legal range is 0 to SCAN_DIV-1.

Ports:
- clk  in  1  system clock
- clr_n  in  1  reset; one clock; reset is asynchronous and active-low
- value  in  16  display value; digit 0 = value[3:0] (rightmost), digit 3 = value[15:12]
- dp_in  in  4  decimal point request per digit, active-high; bit i belongs to digit i
- x  out  4  nibble for hex7seg, registered
- an  out  4  digit anodes, active-low, registered; an[i] drives digit i
- dp  out  1  decimal point, active-low, registered
- frame_tick  out  1  one-cycle pulse when a new frame begins (shadow capture cycle)

Behaviour:
- Reset (clr_n=0, async) values:
  - prescaler=0, digit index=0, shadow value=0, shadow dp=0.
  - x=4'h0, an=4'b1111, dp=1, frame_tick=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - Width is $clog2(SCAN_DIV).
- Digit index:
  - 2-bit, advances 0→1→2→3→0 on the cycle the prescaler wraps (terminal count SCAN_DIV-1).
- Shadow capture:
  - value and dp_in are captured into the shadow registers on the cycle the prescaler wraps while the digit index is 3 (the frame boundary).
  - frame_tick is high on that same cycle.
  - First capture after reset occurs at the end of the first full frame (4*SCAN_DIV cycles). Until then the display shows 0.
- Slot outputs, registered (one cycle after the prescaler/index state they derive from):
  - x = shadow nibble of the current digit.
  - Blank window (prescaler < BLANK_CYCLES): an=4'b1111, dp=1.
  - Otherwise: an = all ones except bit[index]=0; dp = ~shadow_dp[index].
  - x updates at the slot start even while blanked.
- Exactly one anode is low at any time outside blank windows. Two or more low anodes is an error.
- value/dp_in changes mid-frame have no visible effect until the next frame boundary.
- Reset mid-scan: all state returns to reset values immediately. Scanning restarts at digit 0 with a fresh frame after clr_n deasserts.
- Frame period = 4*SCAN_DIV cycles exactly. frame_tick period is the same.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits 3..1 are suppressed (anode held high, dp held high) during their slot when their shadow nibble and every higher shadow nibble are 0.
  - Digit 0 is never suppressed.
  - A digit whose shadow dp bit is 1 is never suppressed, and neither is any digit below it.
  - Evaluation uses shadow values only.
- Undefined: all four digits are always displayed, including leading zeros. Suppression logic is absent.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=1 unless noted):
- Reset and basic scan:
  - Stimulus: clr_n low 3 cycles then high; value=16'h1234.
  - Required: an=1111, dp=1, x=0 during reset.
  - Required: the first frame shows x=0 on all digits.
  - Required: frame_tick at cycle 32 after release.
  - Required: the next frame shows x=4,3,2,1 with an=1110,1101,1011,0111 across consecutive 8-cycle slots.
- Blanking:
  - Required: the first registered cycle of every slot has an=1111.
  - Required: with BLANK_CYCLES=0, an is never 1111 after the first frame and exactly one bit is low.
- Tear-free capture:
  - Stimulus: change value 16'h1234→16'h5678 mid-frame, during digit 1.
  - Required: the remaining slots still show 3,2,1 (i.e. 16'h1234).
  - Required: the following frame shows 8,7,6,5.
- Decimal point:
  - Stimulus: dp_in=4'b0100.
  - Required: dp=0 only during the non-blanked part of digit-2 slots; dp=1 elsewhere.
- Reset mid-scan:
  - Stimulus: assert clr_n low during digit 2, asynchronously (between clock edges).
  - Required: an=1111 and x=0 without waiting for a clock edge.
  - Required: after release, scan resumes at digit 0 and frame_tick appears 32 cycles later.
- LEADING_ZERO_BLANK_EN defined:
  - Stimulus: value=16'h0040, dp_in=0.
  - Required: digits 3 and 2 stay an-high; digit 1 shows 4; digit 0 shows 0.
  - Stimulus: value=16'h0000, dp_in=4'b1000.
  - Required: all four digits displayed.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed 7-segment scan controller with a per-frame shadow capture.
// Define LEADING_ZERO_BLANK_EN to suppress leading-zero digits (shadow values only).
module seg7_scan #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   output logic [3:0]  x,
   output logic [3:0]  an,
   output logic        dp,
   output logic        frame_tick
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] TERM = PW'(SCAN_DIV - 1);

   logic [PW-1:0] presc_reg;
   logic [PW-1:0] presc_next;
   logic [1:0]    idx_reg;
   logic [15:0]   shadow_val_reg;
   logic [3:0]    shadow_dp_reg;
   logic          wrap;
   logic          frame_end;
   logic          blank;
   logic [3:0]    cur_nib;
   logic [3:0]    supp;
   logic [3:0]    sel;
   logic [3:0]    an_next;
   logic          dp_next;

   assign wrap       = (presc_reg == TERM);
   assign frame_end  = wrap && (idx_reg == 2'd3);
   assign presc_next = wrap ? '0 : presc_reg + 1'b1;
   assign cur_nib    = shadow_val_reg[{idx_reg, 2'b00} +: 4];

   generate
      if (BLANK_CYCLES == 0) begin : g_noblank
         assign blank = 1'b0;
      end else begin : g_blank
         localparam logic [PW-1:0] BLANK_L = PW'(BLANK_CYCLES);
         assign blank = (presc_reg < BLANK_L);
      end
   endgenerate

   genvar gi;

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is dark only if it and everything above it is zero with no dp requested.
   assign supp[0] = 1'b0;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_supp
         assign supp[gi] = (shadow_val_reg[15:4*gi] == '0) && (shadow_dp_reg[3:gi] == '0);
      end
   endgenerate
`else
   assign supp = 4'b0000;
`endif

   generate
      for (gi = 0; gi < 4; gi++) begin : g_an
         assign sel[gi]     = (idx_reg == 2'(gi));
         assign an_next[gi] = ~sel[gi] | blank | supp[gi];
      end
   endgenerate

   assign dp_next = blank | supp[idx_reg] | ~shadow_dp_reg[idx_reg];

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         presc_reg      <= '0;
         idx_reg        <= 2'd0;
         shadow_val_reg <= 16'h0000;
         shadow_dp_reg  <= 4'h0;
         x              <= 4'h0;
         an             <= 4'hF;
         dp             <= 1'b1;
         frame_tick     <= 1'b0;
      end else begin
         presc_reg <= presc_next;
         if (wrap) begin
            idx_reg <= idx_reg + 2'd1;
         end
         // Capture only at the frame boundary so a changing count never tears mid-scan.
         if (frame_end) begin
            shadow_val_reg <= value;
            shadow_dp_reg  <= dp_in;
         end
         x          <= cur_nib;
         an         <= an_next;
         dp         <= dp_next;
         frame_tick <= frame_end;
      end
   end
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (BLANK_CYCLES=1 and 0) checked against a frame-level model.
module tb_seg7_scan;
   logic        clk = 1'b0;
   logic        clr_n;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  x, an, x_nb, an_nb;
   logic        dp, frame_tick, dp_nb, ft_nb;

   int total = 0;
   int bad   = 0;
   int n     = 0;
   int slot  = 0;
   int pos   = 0;

   logic [15:0] m_val;
   logic [3:0]  m_dp;
   logic [3:0]  exp_x, exp_an, exp_an_nb;
   logic        exp_dp, exp_dp_nb, exp_ft;

   always #5 clk = ~clk;

   seg7_scan #(.SCAN_DIV(8), .BLANK_CYCLES(1)) dut (
      .clk(clk), .clr_n(clr_n), .value(value), .dp_in(dp_in),
      .x(x), .an(an), .dp(dp), .frame_tick(frame_tick)
   );

   seg7_scan #(.SCAN_DIV(8), .BLANK_CYCLES(0)) dut_nb (
      .clk(clk), .clr_n(clr_n), .value(value), .dp_in(dp_in),
      .x(x_nb), .an(an_nb), .dp(dp_nb), .frame_tick(ft_nb)
   );

   // Advance one clock; n counts edges since reset release. Outputs after edge n
   // show the slot of cycle n-1 using the value latched at the last 32-edge boundary.
   task automatic tick();
      logic [15:0] sh;
      logic [3:0]  oh;
      logic        sup;
      @(posedge clk);
      n++;
      slot = ((n - 1) / 8) % 4;
      pos  = (n - 1) % 8;
      sh   = m_val >> (4 * slot);
      oh   = 4'b0001 << slot;
      sup  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      sup = (slot != 0) && (sh == 16'h0000) && ((m_dp >> slot) == 4'h0);
`endif
      exp_x     = sh[3:0];
      exp_an    = (pos < 1 || sup) ? 4'hF : ~oh;
      exp_dp    = (pos < 1 || sup) ? 1'b1 : ~m_dp[slot];
      exp_an_nb = sup ? 4'hF : ~oh;
      exp_dp_nb = sup ? 1'b1 : ~m_dp[slot];
      exp_ft    = (n % 32 == 0);
      if (n % 32 == 0) begin
         m_val = value;
         m_dp  = dp_in;
      end
      #1;
   endtask

   task automatic release_reset();
      clr_n = 1'b1;
      n     = 0;
      m_val = 16'h0000;
      m_dp  = 4'h0;
   endtask

   task automatic test_reset();
      clr_n = 1'b1;
      value = 16'h1234;
      dp_in = 4'h0;
      #2 clr_n = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         total++;
         if ({x, an, dp, frame_tick, x_nb, an_nb, dp_nb, ft_nb} !== {4'h0, 4'hF, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_state c=%0d got x=%h an=%b dp=%b ft=%b nb_an=%b want x=0 an=1111 dp=1 ft=0",
                     c, x, an, dp, frame_tick, an_nb);
         end
         @(posedge clk);
         #1;
      end
      release_reset();
      $display("test_reset: checks=%0d", total);
   endtask

   task automatic test_basic_scan();
      logic [3:0] tbl [4];
      int ft_first;
      tbl = '{4'h4, 4'h3, 4'h2, 4'h1};
      ft_first = -1;
      for (int c = 0; c < 64; c++) begin
         tick();
         total++;
         if ({x, an, dp, frame_tick, x_nb, an_nb, dp_nb, ft_nb} !== {exp_x, exp_an, exp_dp, exp_ft, exp_x, exp_an_nb, exp_dp_nb, exp_ft}) begin
            bad++;
            $display("FAIL basic_model n=%0d got x=%h an=%b dp=%b ft=%b nb_an=%b nb_dp=%b want x=%h an=%b dp=%b ft=%b nb_an=%b nb_dp=%b",
                     n, x, an, dp, frame_tick, an_nb, dp_nb, exp_x, exp_an, exp_dp, exp_ft, exp_an_nb, exp_dp_nb);
         end
         if (frame_tick === 1'b1 && ft_first < 0) ft_first = n;
         if (n > 32 && pos == 4) begin
            total++;
            if (x !== tbl[slot] || an !== ~(4'b0001 << slot)) begin
               bad++;
               $display("FAIL basic_digit slot=%0d got x=%h an=%b want x=%h an=%b", slot, x, an, tbl[slot], ~(4'b0001 << slot));
            end
         end
      end
      total++;
      if (ft_first != 32) begin
         bad++;
         $display("FAIL basic_first_tick got cycle=%0d want 32", ft_first);
      end
      $display("test_basic_scan: checks=%0d", total);
   endtask

   task automatic test_blanking();
      for (int c = 0; c < 64; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            value = 16'($urandom);
            dp_in = 4'($urandom);
         end
         tick();
         total++;
         if ({x, an, dp, frame_tick, x_nb, an_nb, dp_nb, ft_nb} !== {exp_x, exp_an, exp_dp, exp_ft, exp_x, exp_an_nb, exp_dp_nb, exp_ft}) begin
            bad++;
            $display("FAIL blank_model n=%0d got x=%h an=%b dp=%b ft=%b nb_an=%b nb_dp=%b want x=%h an=%b dp=%b ft=%b nb_an=%b nb_dp=%b",
                     n, x, an, dp, frame_tick, an_nb, dp_nb, exp_x, exp_an, exp_dp, exp_ft, exp_an_nb, exp_dp_nb);
         end
         if (pos == 0) begin
            total++;
            if (an !== 4'hF) begin
               bad++;
               $display("FAIL blank_slot_start n=%0d got an=%b want 1111", n, an);
            end
         end
`ifndef LEADING_ZERO_BLANK_EN
         total++;
         if ($countones(~an_nb) != 1) begin
            bad++;
            $display("FAIL noblank_one_hot n=%0d got an=%b want exactly one low", n, an_nb);
         end
`endif
      end
      $display("test_blanking: checks=%0d", total);
   endtask

   task automatic test_tear_free();
      logic [3:0] seq [7];
      int k;
      seq = '{4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
      k = 0;
      value = 16'h1234;
      dp_in = 4'h0;
      for (int c = 0; c < 32; c++) begin
         tick();
         if (n % 32 == 0) break;
      end
      for (int c = 0; c < 10; c++) tick();
      value = 16'h5678;
      for (int c = 0; c < 54; c++) begin
         tick();
         total++;
         if ({x, an, dp, frame_tick} !== {exp_x, exp_an, exp_dp, exp_ft}) begin
            bad++;
            $display("FAIL tear_model n=%0d got x=%h an=%b dp=%b ft=%b want x=%h an=%b dp=%b ft=%b",
                     n, x, an, dp, frame_tick, exp_x, exp_an, exp_dp, exp_ft);
         end
         if (pos == 4 && k < 7) begin
            total++;
            if (x !== seq[k]) begin
               bad++;
               $display("FAIL tear_digit k=%0d slot=%0d got x=%h want x=%h", k, slot, x, seq[k]);
            end
            k++;
         end
      end
      total++;
      if (k != 7) begin
         bad++;
         $display("FAIL tear_count got %0d slots want 7", k);
      end
      $display("test_tear_free: checks=%0d", total);
   endtask

   task automatic test_dp();
      logic want;
      dp_in = 4'b0100;
      value = 16'($urandom);
      for (int c = 0; c < 32; c++) begin
         tick();
         if (n % 32 == 0) break;
      end
      for (int c = 0; c < 64; c++) begin
         if ($urandom_range(0, 4) == 0) value = 16'($urandom);
         tick();
         total++;
         if ({x, an, dp, x_nb, an_nb, dp_nb} !== {exp_x, exp_an, exp_dp, exp_x, exp_an_nb, exp_dp_nb}) begin
            bad++;
            $display("FAIL dp_model n=%0d got x=%h an=%b dp=%b nb_dp=%b want x=%h an=%b dp=%b nb_dp=%b",
                     n, x, an, dp, dp_nb, exp_x, exp_an, exp_dp, exp_dp_nb);
         end
         want = !(slot == 2 && pos >= 1);
         total++;
         if (dp !== want) begin
            bad++;
            $display("FAIL dp_digit2 n=%0d slot=%0d pos=%0d got dp=%b want dp=%b", n, slot, pos, dp, want);
         end
      end
      $display("test_dp: checks=%0d", total);
   endtask

   task automatic test_reset_midscan();
      int ft_first;
      ft_first = -1;
      for (int c = 0; c < 32; c++) begin
         tick();
         if (n % 32 == 20) break;
      end
      #2 clr_n = 1'b0;
      #1;
      total++;
      if ({x, an, dp, frame_tick, an_nb} !== {4'h0, 4'hF, 1'b1, 1'b0, 4'hF}) begin
         bad++;
         $display("FAIL midscan_async got x=%h an=%b dp=%b ft=%b nb_an=%b want x=0 an=1111 dp=1 ft=0 nb_an=1111",
                  x, an, dp, frame_tick, an_nb);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      release_reset();
      value = 16'hBEEF;
      dp_in = 4'b1111;
      for (int c = 0; c < 40; c++) begin
         tick();
         total++;
         if ({x, an, dp, frame_tick, x_nb, an_nb, dp_nb} !== {exp_x, exp_an, exp_dp, exp_ft, exp_x, exp_an_nb, exp_dp_nb}) begin
            bad++;
            $display("FAIL midscan_model n=%0d got x=%h an=%b dp=%b ft=%b want x=%h an=%b dp=%b ft=%b",
                     n, x, an, dp, frame_tick, exp_x, exp_an, exp_dp, exp_ft);
         end
         if (frame_tick === 1'b1 && ft_first < 0) ft_first = n;
      end
      total++;
      if (ft_first != 32) begin
         bad++;
         $display("FAIL midscan_first_tick got cycle=%0d want 32", ft_first);
      end
      $display("test_reset_midscan: checks=%0d", total);
   endtask

   task automatic test_leading_zero();
      logic [3:0] want_an;
      for (int p = 0; p < 2; p++) begin
         value = (p == 0) ? 16'h0040 : 16'h0000;
         dp_in = (p == 0) ? 4'b0000 : 4'b1000;
         for (int c = 0; c < 32; c++) begin
            tick();
            if (n % 32 == 0) break;
         end
         for (int c = 0; c < 32; c++) begin
            tick();
            total++;
            if ({x, an, dp} !== {exp_x, exp_an, exp_dp}) begin
               bad++;
               $display("FAIL lzb_model p=%0d n=%0d got x=%h an=%b dp=%b want x=%h an=%b dp=%b",
                        p, n, x, an, dp, exp_x, exp_an, exp_dp);
            end
            if (pos == 4) begin
               want_an = ~(4'b0001 << slot);
`ifdef LEADING_ZERO_BLANK_EN
               if (p == 0 && slot >= 2) want_an = 4'hF;
`endif
               total++;
               if (an !== want_an || x !== ((p == 0 && slot == 1) ? 4'h4 : 4'h0)) begin
                  bad++;
                  $display("FAIL lzb_digit p=%0d slot=%0d got x=%h an=%b want an=%b", p, slot, x, an, want_an);
               end
            end
         end
      end
      $display("test_leading_zero: checks=%0d", total);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_scan();
      test_blanking();
      test_tear_free();
      test_dp();
      test_reset_midscan();
      test_leading_zero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
